// File: rtl/gon_xbus_ctrl.sv
// gon_xbus_ctrl: sequencing controller for one GON X-bus.
// Buffers tagged packets from the GLB read port, holds the per-column ID
// table, and strobes the bus only when every targeted column is ready.
// Packets whose tag matches no column are discarded and counted.
module gon_xbus_ctrl #(
   parameter int DATA_WIDTH    = 64,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_COLS   = 14,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_load,
   input  logic [COL_TAG_WIDTH-1:0] cfg_col_id [0:NUM_OF_COLS-1],
   output logic [COL_TAG_WIDTH-1:0] col_id     [0:NUM_OF_COLS-1],
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [COL_TAG_WIDTH-1:0] src_tag,
   input  logic [DATA_WIDTH-1:0]    src_data,
   input  logic [0:NUM_OF_COLS-1]   col_ready,
   output logic [COL_TAG_WIDTH-1:0] bus_tag,
   output logic [DATA_WIDTH-1:0]    bus_data,
   output logic                     bus_enable,
   output logic [15:0]              drop_count,
   output logic                     cfg_err,
   output logic                     busy
);

   localparam int                     PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]         DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [COL_TAG_WIDTH-1:0] BCAST_TAG = '1;

   typedef enum logic {ST_CONFIG, ST_RUN} state_t;

   state_t                   state;
   logic [COL_TAG_WIDTH-1:0] tag_mem  [0:FIFO_DEPTH-1];
   logic [DATA_WIDTH-1:0]    data_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W:0]           count;

   logic                     empty;
   logic                     full;
   logic                     push;
   logic                     pop;
   logic                     run;
   logic                     drop;
   logic                     targets_ready;
   logic [COL_TAG_WIDTH-1:0] head_tag;
   logic [DATA_WIDTH-1:0]    head_data;
   logic [0:NUM_OF_COLS-1]   match_mask;

   assign empty     = (count == '0);
   assign full      = (count == DEPTH_CNT);
   assign src_ready = !full;
   assign busy      = !empty;
   assign push      = src_valid && !full;
   assign run       = (state == ST_RUN);

   assign head_tag  = tag_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign bus_tag   = empty ? '0 : head_tag;
   assign bus_data  = empty ? '0 : head_data;

   // Which columns the head packet targets; the broadcast tag hits them all.
   always_comb begin
      match_mask = '0;
      for (int i = 0; i < NUM_OF_COLS; i++) begin
         match_mask[i] = (head_tag == BCAST_TAG) || (col_id[i] == head_tag);
      end
   end

   // Only targeted columns gate the transfer; the rest are masked off.
   assign targets_ready = (match_mask != '0) && ((col_ready & match_mask) == match_mask);
   assign drop          = run && !empty && (match_mask == '0);
   assign bus_enable    = run && !empty && targets_ready;
   assign pop           = drop || bus_enable;

   // Packet storage written on push.
   // NOTE: the storage array has no reset; emptiness is tracked by count and
   // the bus outputs are forced to zero when empty, so stale contents never leak.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr]  <= src_tag;
         data_mem[wr_ptr] <= src_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Control FSM: ID table loading, config error flag and drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_CONFIG;
         drop_count <= '0;
         cfg_err    <= 1'b0;
         for (int i = 0; i < NUM_OF_COLS; i++) begin
            col_id[i] <= '0;
         end
      end else begin
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
         case (state)
            ST_CONFIG: begin
               if (cfg_load) begin
                  col_id <= cfg_col_id;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Reloading under buffered packets would retarget them mid-flight.
               if (cfg_load) begin
                  if (empty) col_id  <= cfg_col_id;
                  else       cfg_err <= 1'b1;
               end
            end
            default: state <= ST_CONFIG;
         endcase
      end
   end

endmodule

// File: tb/tb_gon_xbus_ctrl.sv
// tb_gon_xbus_ctrl: directed scenarios plus randomized traffic for
// gon_xbus_ctrl, checked every cycle against a packet-queue model.
module tb_gon_xbus_ctrl;

   localparam int DW    = 64;
   localparam int TW    = 4;
   localparam int NC    = 14;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } pkt_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_load = 1'b0;
   logic [TW-1:0] cfg_col_id [0:NC-1];
   logic [TW-1:0] col_id     [0:NC-1];
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [TW-1:0] src_tag = '0;
   logic [DW-1:0] src_data = '0;
   logic [0:NC-1] col_ready = '0;
   logic [TW-1:0] bus_tag;
   logic [DW-1:0] bus_data;
   logic          bus_enable;
   logic [15:0]   drop_count;
   logic          cfg_err;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // Reference model state
   pkt_t          q[$];
   logic [TW-1:0] m_tbl [0:NC-1];
   bit            m_run = 1'b0;
   logic [15:0]   m_drops = '0;
   bit            m_err = 1'b0;

   gon_xbus_ctrl #(
      .DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_col_id(cfg_col_id),
      .col_id(col_id), .src_valid(src_valid), .src_ready(src_ready),
      .src_tag(src_tag), .src_data(src_data), .col_ready(col_ready),
      .bus_tag(bus_tag), .bus_data(bus_data), .bus_enable(bus_enable),
      .drop_count(drop_count), .cfg_err(cfg_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Head packet status from the model: does it target any column, and are all targets ready.
   function automatic void head_status(output bit any, output bit ok);
      any = 1'b0;
      ok  = 1'b1;
      if (q.size() == 0) return;
      for (int i = 0; i < NC; i++) begin
         if (q[0].tag == 4'hF || m_tbl[i] == q[0].tag) begin
            any = 1'b1;
            if (!col_ready[i]) ok = 1'b0;
         end
      end
   endfunction

   // Model update at each clock edge, cleared by reset.
   initial begin
      for (int i = 0; i < NC; i++) m_tbl[i] = '0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            q.delete();
            m_run   = 1'b0;
            m_drops = '0;
            m_err   = 1'b0;
            for (int i = 0; i < NC; i++) m_tbl[i] = '0;
         end else begin
            int   sz;
            bit   acc, any, ok;
            pkt_t p;
            sz  = q.size();
            acc = src_valid && (sz < DEPTH);
            p.tag  = src_tag;
            p.data = src_data;
            head_status(any, ok);
            if (m_run && sz > 0) begin
               if (!any) begin
                  void'(q.pop_front());
                  if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
               end else if (ok) begin
                  void'(q.pop_front());
               end
            end
            if (cfg_load) begin
               if (!m_run) begin
                  m_tbl = cfg_col_id;
                  m_run = 1'b1;
               end else if (sz == 0) begin
                  m_tbl = cfg_col_id;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (acc) q.push_back(p);
         end
      end
   end

   // Compare every output against the model mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            bit            any, ok;
            logic [TW*NC-1:0] act_ids, exp_ids;
            head_status(any, ok);
            for (int i = 0; i < NC; i++) begin
               act_ids[i*TW +: TW] = col_id[i];
               exp_ids[i*TW +: TW] = m_tbl[i];
            end
            check("m_src_ready", src_ready, q.size() < DEPTH);
            check("m_busy", busy, q.size() != 0);
            check("m_bus_enable", bus_enable, m_run && q.size() != 0 && any && ok);
            check("m_bus_tag", bus_tag, (q.size() != 0) ? q[0].tag : '0);
            check("m_bus_data", bus_data, (q.size() != 0) ? q[0].data : '0);
            check("m_drop_count", drop_count, m_drops);
            check("m_cfg_err", cfg_err, m_err);
            check("m_col_id", act_ids, exp_ids);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ids_linear();
      for (int i = 0; i < NC; i++) cfg_col_id[i] = TW'(i);
   endtask

   initial begin
      logic [0:NC-1] cr;
      for (int i = 0; i < NC; i++) cfg_col_id[i] = '0;

      // Reset values
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_src_ready", src_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_bus_enable", bus_enable, 1'b0);
      check("rst_bus_tag", bus_tag, 4'h0);
      check("rst_bus_data", bus_data, 64'h0);
      check("rst_drop_count", drop_count, 16'h0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_col_id5", col_id[5], 4'h0);

      // IDs 0..13, single packet with all columns ready
      set_ids_linear();
      cfg_load = 1'b1;
      tick();
      cfg_load  = 1'b0;
      src_valid = 1'b1; src_tag = 4'd5; src_data = 64'hA5; col_ready = '1;
      @(negedge clk);
      check("lat_en_before", bus_enable, 1'b0);
      tick();
      src_valid = 1'b0;
      @(negedge clk);
      check("lat_en", bus_enable, 1'b1);
      check("lat_data", bus_data, 64'hA5);
      check("lat_tag", bus_tag, 4'd5);
      check("lat_col_id13", col_id[13], 4'd13);
      tick();
      @(negedge clk);
      check("lat_busy_after", busy, 1'b0);
      check("lat_en_after", bus_enable, 1'b0);

      // IDs {0,0,1,1,...}: tag 0 stalls on column 1 only
      for (int i = 0; i < NC; i++) cfg_col_id[i] = TW'(i / 2);
      cfg_load = 1'b1;
      tick();
      cfg_load  = 1'b0;
      src_valid = 1'b1; src_tag = 4'd0; src_data = 64'h11;
      col_ready = 14'b10_1111_1111_1111;
      tick();
      src_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_en", bus_enable, 1'b0);
         check("stall_busy", busy, 1'b1);
         tick();
      end
      col_ready = 14'b11_0000_0000_0000;
      @(negedge clk);
      check("stall_release_en", bus_enable, 1'b1);
      check("stall_release_data", bus_data, 64'h11);
      tick();
      @(negedge clk);
      check("stall_single_en", bus_enable, 1'b0);
      check("stall_busy_after", busy, 1'b0);

      // Broadcast tag waits on column 7
      cr = '1;
      cr[7] = 1'b0;
      col_ready = cr;
      src_valid = 1'b1; src_tag = 4'hF; src_data = 64'h33;
      tick();
      src_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("bcast_stall_en", bus_enable, 1'b0);
         tick();
      end
      col_ready = '1;
      @(negedge clk);
      check("bcast_en", bus_enable, 1'b1);
      tick();
      @(negedge clk);
      check("bcast_single_en", bus_enable, 1'b0);

      // Unmatched tag dropped, next packet issues right after
      src_valid = 1'b1; src_tag = 4'd7; src_data = 64'h77;
      tick();
      src_tag = 4'd3; src_data = 64'h44;
      @(negedge clk);
      check("drop_en", bus_enable, 1'b0);
      check("drop_cnt_before", drop_count, 16'd0);
      tick();
      src_valid = 1'b0;
      @(negedge clk);
      check("drop_cnt_after", drop_count, 16'd1);
      check("drop_next_en", bus_enable, 1'b1);
      check("drop_next_data", bus_data, 64'h44);
      tick();

      // Saturate the drop counter
      src_valid = 1'b1; src_tag = 4'd7; src_data = 64'h0;
      repeat (65540) tick();
      src_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("drop_saturated", drop_count, 16'hFFFF);
      tick();

      // Fill to full with no column ready, then drain in order
      col_ready = '0;
      src_tag   = 4'd3;
      for (int i = 0; i < 4; i++) begin
         src_valid = 1'b1;
         src_data  = 64'h100 + 64'(i);
         tick();
      end
      src_data  = 64'h104;
      col_ready = '1;
      @(negedge clk);
      check("full_src_ready", src_ready, 1'b0);
      check("drain0", bus_data, 64'h100);
      check("drain0_en", bus_enable, 1'b1);
      tick();
      @(negedge clk);
      check("drain1", bus_data, 64'h101);
      check("drain1_src_ready", src_ready, 1'b1);
      tick();
      src_valid = 1'b0;
      for (int i = 2; i < 5; i++) begin
         @(negedge clk);
         check("drain_order", bus_data, 64'h100 + 64'(i));
         check("drain_en", bus_enable, 1'b1);
         tick();
      end
      @(negedge clk);
      check("drain_empty", busy, 1'b0);

      // Push before configuration: held until cfg_load
      reset = 1'b1;
      tick();
      reset = 1'b0;
      col_ready = '1;
      src_valid = 1'b1; src_tag = 4'd2; src_data = 64'h22;
      tick();
      src_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("cfgwait_en", bus_enable, 1'b0);
         check("cfgwait_busy", busy, 1'b1);
         tick();
      end
      set_ids_linear();
      cfg_load = 1'b1;
      @(negedge clk);
      check("cfgwait_en_loadcycle", bus_enable, 1'b0);
      tick();
      cfg_load = 1'b0;
      @(negedge clk);
      check("cfgwait_en_run", bus_enable, 1'b1);
      check("cfgwait_data", bus_data, 64'h22);
      tick();

      // Reload while FIFO non-empty is rejected
      col_ready = '0;
      src_valid = 1'b1; src_tag = 4'd2; src_data = 64'h23;
      tick();
      src_valid = 1'b0;
      for (int i = 0; i < NC; i++) cfg_col_id[i] = 4'd9;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      @(negedge clk);
      check("cfgerr_set", cfg_err, 1'b1);
      check("cfgerr_col_id2", col_id[2], 4'd2);
      check("cfgerr_col_id0", col_id[0], 4'd0);
      col_ready = '1;
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         src_valid = ($urandom_range(0, 3) != 0);
         src_tag   = TW'($urandom_range(0, 15));
         src_data  = {$urandom(), $urandom()};
         for (int i = 0; i < NC; i++) cr[i] = ($urandom_range(0, 3) != 0);
         col_ready = (c % 8 == 0) ? '1 : cr;
         cfg_load  = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < NC; i++) cfg_col_id[i] = TW'($urandom_range(0, 7));
         tick();
      end
      cfg_load  = 1'b0;
      src_valid = 1'b0;

      // Reset mid-stream clears everything without a clock edge
      col_ready = '0;
      src_valid = 1'b1; src_tag = 4'hF; src_data = 64'h55;
      repeat (2) tick();
      src_valid = 1'b0;
      col_ready = '1;
      @(negedge clk);
      check("midrst_en_before", bus_enable, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_en", bus_enable, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_src_ready", src_ready, 1'b1);
      check("midrst_bus_data", bus_data, 64'h0);
      check("midrst_bus_tag", bus_tag, 4'h0);
      check("midrst_drop", drop_count, 16'h0);
      check("midrst_cfg_err", cfg_err, 1'b0);
      check("midrst_col_id3", col_id[3], 4'h0);
      tick();
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gon_xbus_ctrl.md
# gon_xbus_ctrl

Sequencing controller for the GON X-bus. It buffers tagged packets from the global buffer side and holds the per-column ID table that drives the bus's column IDs. For each packet it computes which columns the tag targets and raises the bus enable only when every targeted column reports ready. It sits between the GLB read port and the X-bus, one instance per X-bus.

## Interface
- DATA_WIDTH, 64, payload width
- COL_TAG_WIDTH, 4, width of column tag/ID
- NUM_OF_COLS, 14, columns on the X-bus
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥2)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- cfg_load  input  1  latch cfg_col_id into ID table
- cfg_col_id  input  [COL_TAG_WIDTH-1:0] x NUM_OF_COLS (unpacked [0:NUM_OF_COLS-1])  column ID values to load
- col_id  output  same shape as cfg_col_id  registered ID table, drives X-bus column IDs
- src_valid  input  1  upstream packet valid
- src_ready  output  1  controller can accept packet
- src_tag  input  COL_TAG_WIDTH  destination column tag
- src_data  input  DATA_WIDTH  payload
- col_ready  input  [0:NUM_OF_COLS-1]  per-column ready returned by X-bus
- bus_tag  output  COL_TAG_WIDTH  tag of FIFO head
- bus_data  output  DATA_WIDTH  payload of FIFO head
- bus_enable  output  1  transfer strobe to X-bus
- drop_count  output  16  packets discarded (no matching column)
- cfg_err  output  1  sticky: cfg_load rejected
- busy  output  1  FIFO non-empty

## Operation
- States: CONFIG (after reset), RUN.
- CONFIG
  - bus_enable = 0.
  - src_ready = !full, so packets may be buffered but are not issued.
  - cfg_load moves to RUN and latches the ID table.
- RUN: issues from the FIFO head each cycle.
  - Match mask: bit i = (col_id[i] == head tag).
  - Broadcast tag {COL_TAG_WIDTH{1'b1}}: mask = all ones.
- Issue rule, FIFO non-empty, state RUN:
  - mask == 0: head popped at the edge, bus_enable stays 0, drop_count += 1. drop_count saturates at 16'hFFFF.
  - mask != 0 and (col_ready & mask) == mask: bus_enable = 1 and head popped at the edge. Non-targeted columns' ready is ignored.
  - Otherwise: stall, head held, bus_enable = 0.
- cfg_load in RUN:
  - Accepted only when the FIFO is empty; table reloaded, state stays RUN.
  - If the FIFO is non-empty, the load is ignored and cfg_err is set (sticky until reset).
- FIFO
  - Push when src_valid && src_ready.
  - src_ready = !full, evaluated from current occupancy. A full FIFO does not accept a push even when a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order strictly preserved; no bypass.
- bus_tag/bus_data always show the FIFO head. They are zero when the FIFO is empty.

## Timing
- Reset values:
  - state CONFIG
  - col_id all 0
  - FIFO empty
  - bus_enable 0, bus_tag 0, bus_data 0
  - src_ready 1
  - drop_count 0, cfg_err 0, busy 0
- bus_enable is combinational from the FIFO head, the ID table and col_ready; the X-bus samples it on the same edge as the pop.
- Latency: a packet accepted at edge t is the head in cycle t+1 if the FIFO was empty. Its bus_enable can assert in cycle t+1, with the transfer at edge t+1.
- Throughput: one transfer or drop per cycle.
- The ID table loaded at edge t is used for matching from cycle t+1. col_id is a registered output.
- Reset asserted mid-transfer discards all buffered packets immediately (asynchronously). bus_enable falls without waiting for a clock.
- drop_count and cfg_err update at the edge of the event.

## Test plan
- Reset, then cfg_load with IDs 0..13. Push tag 5, data 0xA5, with col_ready all ones: bus_enable = 1 exactly one cycle after acceptance, bus_data = 0xA5, busy returns to 0.
- IDs {0,0,1,1,...}, push tag 0, col_ready = 14'b10_1111_1111_1111: stall while column 1 is low. Raise column 1: enable for exactly 1 cycle. Columns 2..13 low never block.
- Push tag 15 with col_ready all ones except col 7 low: stall. Raise col 7: single enable.
- Push a tag matching no column: no enable, drop_count 0→1, the next packet issues in the following cycle. Force the counter to saturate: it holds at 0xFFFF.
- Push 5 packets with col_ready = 0: src_ready drops after 4. Release ready: data emerges in push order, one per cycle.
- Push before cfg_load: no enable until cfg_load. cfg_load with the FIFO non-empty in RUN: table unchanged, cfg_err = 1. Assert reset mid-stream: all outputs return to reset values.
